// File: rtl/pdm_cic_if.sv
// PDM input / PCM output bundle for the CIC decimator.
// master drives the bitstream, slave is the decimator.
interface pdm_cic_if;
  logic               pdm_ce;
  logic               pdm_in;
  logic signed [15:0] pcm_data;
  logic               pcm_valid;
  logic               settled;

  modport master (
    output pdm_ce,
    output pdm_in,
    input  pcm_data,
    input  pcm_valid,
    input  settled
  );

  modport slave (
    input  pdm_ce,
    input  pdm_in,
    output pcm_data,
    output pcm_valid,
    output settled
  );
endinterface

// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator (M=1, R=2^OSR_LOG2).
// Turns a 1-bit PDM stream into saturated signed 16-bit PCM.
module pdm_cic_decimator #(
  parameter int OSR_LOG2 = 7
) (
  input  logic    clk,
  input  logic    reset,
  pdm_cic_if.slave p
);
  localparam int IW = 3*OSR_LOG2 + 2;
  localparam int SH = 3*OSR_LOG2 - 15;

  logic signed [IW-1:0] i1, i2, i3;
  logic signed [IW-1:0] z1, z2, z3;
  logic signed [IW-1:0] x, d1, d2, d3;
  logic [OSR_LOG2-1:0]  cnt;
  logic [2:0]           wcnt;
  logic                 tick;
  logic signed [16:0]   s;
  logic signed [15:0]   sat;
  logic signed [15:0]   data_q;
  logic                 valid_q;
  logic                 settled_q;

  always_comb begin
    x    = p.pdm_in ? IW'(1) : '1;
    tick = p.pdm_ce & (cnt == '1);
    d1   = i3 - z1;
    d2   = d1 - z2;
    d3   = d2 - z3;
    s    = 17'(d3 >>> SH);
    sat  = s[15:0];
    // Only +2^15 can escape the 16-bit range.
    if (s[16] != s[15])
      sat = s[16] ? 16'sh8000 : 16'sh7fff;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      z1        <= '0;
      z2        <= '0;
      z3        <= '0;
      cnt       <= '0;
      wcnt      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      if (p.pdm_ce) begin
        cnt <= cnt + OSR_LOG2'(1);
        i1  <= i1 + x;
        i2  <= i2 + i1;
        i3  <= i3 + i2;
      end
      if (tick) begin
        z1     <= i3;
        z2     <= d1;
        z3     <= d2;
        data_q <= sat;
        if (wcnt != 3'd4)
          wcnt <= wcnt + 3'd1;
      end
      valid_q <= tick & (wcnt == 3'd4);
      if (tick & (wcnt == 3'd3))
        settled_q <= 1'b1;
    end
  end

  assign p.pcm_data  = data_q;
  assign p.pcm_valid = valid_q;
  assign p.settled   = settled_q;
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator at OSR_LOG2=7 and 5.
// Reference: closed-form CIC sums over the recorded bitstream.
module tb_pdm_cic_decimator;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pdm_cic_if a ();
  pdm_cic_if b ();

  pdm_cic_decimator #(.OSR_LOG2(7)) u7 (
    .clk(clk), .reset(reset), .p(a));
  pdm_cic_decimator #(.OSR_LOG2(5)) u5 (
    .clk(clk), .reset(reset), .p(b));

  logic signed [15:0] dat [2];
  logic               val [2];
  logic               stl [2];
  assign dat[0] = a.pcm_data;
  assign dat[1] = b.pcm_data;
  assign val[0] = a.pcm_valid;
  assign val[1] = b.pcm_valid;
  assign stl[0] = a.settled;
  assign stl[1] = b.settled;

  typedef struct {
    string    name;
    bit [7:0] pat;
    int       plen;
    bit       rnd_bits;
    bit       rnd_ce;
    int       frames;
    bit       has_exp;
    int       expv;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int xs[$];
  int n_en;
  bit tk [2];
  int vcount [2];
  int lg [2] = '{7, 5};
  bit has_exp;
  int expv;
  string cur;

  task automatic cmp(string nm, int d,
                     longint act, longint ex);
    tests++;
    if (act != ex) begin
      fails++;
      $display("FAIL %s/%s osr_log2=%0d n=%0d: got %0d expected %0d",
               cur, nm, lg[d], n_en, act, ex);
    end
  endtask

  // Value of the third integrator after n enabled edges.
  function automatic longint i3_at(int n);
    longint acc = 0;
    longint w;
    for (int k = 0; k < n - 2; k++) begin
      w = longint'(n - 1 - k) * longint'(n - 2 - k) / 2;
      acc += longint'(xs[k]) * w;
    end
    return acc;
  endfunction

  function automatic longint model(int lgv, int m);
    int osr = 1 << lgv;
    longint d3;
    longint s;
    d3 = i3_at(osr*m - 1)
       - 3 * i3_at(osr*(m-1) - 1)
       + 3 * i3_at(osr*(m-2) - 1)
       - i3_at(osr*(m-3) - 1);
    s = d3 >>> (3*lgv - 15);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic check_cycle();
    int m;
    bit ev;
    for (int d = 0; d < 2; d++) begin
      m  = n_en >> lg[d];
      ev = tk[d] && (m >= 5);
      cmp("valid", d, longint'(val[d]), longint'(ev));
      cmp("settled", d, longint'(stl[d]),
          longint'(m >= 4));
      if (val[d] && ev) begin
        vcount[d]++;
        cmp("data", d, longint'(dat[d]), model(lg[d], m));
        if (has_exp)
          cmp("const", d, longint'(dat[d]), longint'(expv));
      end
    end
  endtask

  task automatic step(bit ce, bit bv);
    @(negedge clk);
    check_cycle();
    a.pdm_ce = ce;
    a.pdm_in = bv;
    b.pdm_ce = ce;
    b.pdm_in = bv;
    if (ce) begin
      xs.push_back(bv ? 1 : -1);
      n_en++;
    end
    for (int d = 0; d < 2; d++)
      tk[d] = ce && ((n_en % (1 << lg[d])) == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    a.pdm_ce = 1'b0;
    b.pdm_ce = 1'b0;
    xs.delete();
    n_en   = 0;
    tk     = '{0, 0};
    vcount = '{0, 0};
    #1;
    for (int d = 0; d < 2; d++) begin
      cmp("rst_data", d, longint'(dat[d]), 0);
      cmp("rst_valid", d, longint'(val[d]), 0);
      cmp("rst_settled", d, longint'(stl[d]), 0);
    end
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      cmp("rst_hold", d, longint'(dat[d]), 0);
    reset = 1'b1;
  endtask

  task automatic count_check();
    for (int d = 0; d < 2; d++)
      cmp("strobe_count", d, longint'(vcount[d]),
          longint'((n_en >> lg[d]) - 4));
  endtask

  task automatic run(vec_t v, int target);
    bit ce;
    bit bv;
    while (n_en < target) begin
      ce = v.rnd_ce ? 1'($urandom_range(0, 1)) : 1'b1;
      bv = v.rnd_bits ? 1'($urandom_range(0, 1))
                      : v.pat[n_en % v.plen];
      step(ce, bv);
    end
    step(1'b0, 1'b0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"const1", 8'h01, 1, 0, 0, 12, 1, 32767};
    vecs[1] = '{"const0", 8'h00, 1, 0, 0, 40, 1, -32768};
    vecs[2] = '{"alt10", 8'h01, 2, 0, 0, 10, 1, 0};
    vecs[3] = '{"p1110", 8'h07, 4, 0, 0, 10, 1, 16384};
    vecs[4] = '{"p1110_ce", 8'h07, 4, 0, 1, 10, 1, 16384};
    vecs[5] = '{"alt10_ce", 8'h01, 2, 0, 1, 8, 1, 0};
    vecs[6] = '{"rnd", 8'h00, 1, 1, 0, 12, 0, 0};
    vecs[7] = '{"rnd_ce", 8'h00, 1, 1, 1, 8, 0, 0};

    reset    = 1'b0;
    a.pdm_ce = 1'b0;
    a.pdm_in = 1'b0;
    b.pdm_ce = 1'b0;
    b.pdm_in = 1'b0;
    n_en     = 0;
    has_exp  = 0;
    expv     = 0;
    cur      = "init";

    for (int i = 0; i < 8; i++) begin
      cur     = vecs[i].name;
      has_exp = vecs[i].has_exp;
      expv    = vecs[i].expv;
      do_reset();
      run(vecs[i], vecs[i].frames * 128);
      count_check();
    end

    // Tick edge followed by pdm_ce low: strobe must still appear.
    cur     = "tick_ce_low";
    has_exp = 1;
    expv    = 32767;
    do_reset();
    repeat (640) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    #1;
    cmp("pulse", 0, longint'(val[0]), 1);
    cmp("pulse_data", 0, longint'(dat[0]), 32767);
    repeat (3) step(1'b0, 1'b1);
    cmp("pulse_count", 0, longint'(vcount[0]), 1);

    // Reset mid-frame after settling, then resume.
    cur     = "mid_reset";
    has_exp = 1;
    expv    = 16384;
    do_reset();
    run(vecs[3], 7*128 + 60);
    cmp("pre_settled", 0, longint'(stl[0]), 1);
    do_reset();
    run(vecs[3], 8*128);
    count_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
